// File: rtl/dma_read_block.sv
// Source-side engine of the scatter-gather DMA: command FIFO, Avalon-MM burst reads, data FIFO push.
// Optional: define DMA_RD_STALL_CNT_EN to add the rd_stall_count_o waitrequest stall counter.
module dma_read_block #(
    parameter int CMD_FIFO_DEPTH = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  rd_master_addr_o,
    output logic         rd_master_read_o,
    output logic [10:0]  rd_master_bcount_o,
    input  logic         rd_master_wait_req_i,
    input  logic [255:0] rd_master_data_i,
    input  logic         rd_master_data_valid_i,
    input  logic         dma_rd_fifo_command_req_i,
    input  logic [15:0]  dma_rd_bytes_to_transfer_i,
    input  logic [31:0]  dma_rd_addr_i,
    output logic         dma_rd_fifo_full_o,
    output logic         dma_data_fifo_wr_req_o,
    output logic [255:0] dma_data_o,
    input  logic         dma_data_fifo_almost_full_i,
`ifdef DMA_RD_STALL_CNT_EN
    output logic [31:0]  rd_stall_count_o,
`endif
    output logic         dma_rd_done_o,
    output logic [15:0]  dma_rd_bytes_done_o
);

    localparam int          WIDTHU          = $clog2(CMD_FIFO_DEPTH);
    localparam logic [10:0] MAX_BURST_BEATS = 11'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RD_CMD_FIFO = 3'd1,
        LD_CMD_REG  = 3'd2,
        CHECK       = 3'd3,
        ISSUE       = 3'd4,
        WAIT_DATA   = 3'd5,
        DONE        = 3'd6
    } state_t;

    state_t state, next_state;

    logic [47:0]       cmd_mem [CMD_FIFO_DEPTH];
    logic [WIDTHU-1:0] wr_ptr, rd_ptr;
    logic [WIDTHU:0]   cmd_count;
    logic [47:0]       cmd_q;
    logic              cmd_empty, cmd_full, cmd_push, cmd_pop;

    logic              cmd_rdreq, ld_cmd, issue_start, burst_accept, beat_in;
    logic [15:0]       q_bytes;
    logic [10:0]       q_total_beats;
    logic [10:0]       burst_len;

    logic [15:0]       cmd_bytes;
    logic [31:0]       cmd_addr;
    logic [10:0]       remaining_beats;
    logic [10:0]       beats_issued;
    logic [10:0]       outstanding;

    assign cmd_full           = (cmd_count == (WIDTHU+1)'(CMD_FIFO_DEPTH));
    assign cmd_empty          = (cmd_count == '0);
    assign cmd_push           = dma_rd_fifo_command_req_i & ~cmd_full;
    assign cmd_pop            = cmd_rdreq & ~cmd_empty;
    assign dma_rd_fifo_full_o = cmd_full;

    assign q_bytes       = cmd_q[47:32];
    assign q_total_beats = q_bytes[15:5] + {10'd0, |q_bytes[4:0]};
    assign burst_len     = (remaining_beats > MAX_BURST_BEATS) ? MAX_BURST_BEATS : remaining_beats;

    // Command storage; pushes while full are dropped before reaching here.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[wr_ptr] <= {dma_rd_bytes_to_transfer_i, dma_rd_addr_i};
        end
    end

    // Normal-mode FIFO: q is updated one cycle after the read request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
            cmd_q     <= '0;
        end else begin
            if (cmd_push) begin
                wr_ptr <= wr_ptr + WIDTHU'(1);
            end
            if (cmd_pop) begin
                rd_ptr <= rd_ptr + WIDTHU'(1);
                cmd_q  <= cmd_mem[rd_ptr];
            end
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + (WIDTHU+1)'(1);
                2'b01:   cmd_count <= cmd_count - (WIDTHU+1)'(1);
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (!cmd_empty) next_state = RD_CMD_FIFO;
            RD_CMD_FIFO: next_state = LD_CMD_REG;
            LD_CMD_REG:  next_state = (q_total_beats == '0) ? DONE : CHECK;
            CHECK:       if (!dma_data_fifo_almost_full_i) next_state = ISSUE;
            ISSUE:       if (rd_master_read_o && !rd_master_wait_req_i) next_state = WAIT_DATA;
            WAIT_DATA: begin
                // remaining_beats was already reduced when the burst was accepted.
                if (rd_master_data_valid_i && (outstanding == 11'd1)) begin
                    next_state = (remaining_beats == '0) ? DONE : CHECK;
                end
            end
            DONE:        next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_rdreq    = (state == RD_CMD_FIFO);
        ld_cmd       = (state == LD_CMD_REG);
        issue_start  = (state == CHECK) && !dma_data_fifo_almost_full_i;
        burst_accept = (state == ISSUE) && rd_master_read_o && !rd_master_wait_req_i;
        beat_in      = (state == WAIT_DATA) && rd_master_data_valid_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_bytes              <= '0;
            cmd_addr               <= '0;
            remaining_beats        <= '0;
            beats_issued           <= '0;
            outstanding            <= '0;
            rd_master_addr_o       <= '0;
            rd_master_read_o       <= 1'b0;
            rd_master_bcount_o     <= '0;
            dma_data_fifo_wr_req_o <= 1'b0;
            dma_data_o             <= '0;
            dma_rd_done_o          <= 1'b0;
            dma_rd_bytes_done_o    <= '0;
        end else begin
            if (ld_cmd) begin
                cmd_bytes       <= q_bytes;
                cmd_addr        <= cmd_q[31:0];
                remaining_beats <= q_total_beats;
                beats_issued    <= '0;
            end
            if (issue_start) begin
                rd_master_addr_o   <= cmd_addr + {16'd0, beats_issued, 5'd0};
                rd_master_bcount_o <= burst_len;
                rd_master_read_o   <= 1'b1;
            end
            if (burst_accept) begin
                rd_master_read_o <= 1'b0;
                outstanding      <= rd_master_bcount_o;
                remaining_beats  <= remaining_beats - rd_master_bcount_o;
                beats_issued     <= beats_issued + rd_master_bcount_o;
            end
            if (beat_in) begin
                outstanding <= outstanding - 11'd1;
                dma_data_o  <= rd_master_data_i;
            end
            dma_data_fifo_wr_req_o <= beat_in;
            dma_rd_done_o          <= (state == DONE);
            if (state == DONE) begin
                dma_rd_bytes_done_o <= cmd_bytes;
            end
        end
    end

`ifdef DMA_RD_STALL_CNT_EN
    // Saturating count of cycles the interconnect held off a pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stall_count_o <= '0;
        end else if (rd_master_read_o && rd_master_wait_req_i && (rd_stall_count_o != 32'hFFFF_FFFF)) begin
            rd_stall_count_o <= rd_stall_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_read_block.sv
// Directed self-checking bench for dma_read_block with a simple Avalon-MM read slave model.
// Checks rd_stall_count_o as well when built with DMA_RD_STALL_CNT_EN.
module tb_dma_read_block;

    logic         clk;
    logic         reset;
    logic [31:0]  rd_master_addr_o;
    logic         rd_master_read_o;
    logic [10:0]  rd_master_bcount_o;
    logic         rd_master_wait_req_i;
    logic [255:0] rd_master_data_i;
    logic         rd_master_data_valid_i;
    logic         dma_rd_fifo_command_req_i;
    logic [15:0]  dma_rd_bytes_to_transfer_i;
    logic [31:0]  dma_rd_addr_i;
    logic         dma_rd_fifo_full_o;
    logic         dma_data_fifo_wr_req_o;
    logic [255:0] dma_data_o;
    logic         dma_data_fifo_almost_full_i;
    logic         dma_rd_done_o;
    logic [15:0]  dma_rd_bytes_done_o;
`ifdef DMA_RD_STALL_CNT_EN
    logic [31:0]  rd_stall_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int stall_cfg  = 0;
    int beat_limit = 1000;
    int stray_req  = 0;
    bit slave_busy = 0;

    int read_hi    = 0;
    int stall_seen = 0;
    int overlap    = 0;

    logic [31:0]  burst_addr_q[$];
    logic [10:0]  burst_cnt_q[$];
    logic [255:0] got_data[$];
    int           valid_cyc_q[$];
    int           wr_cyc_q[$];
    logic [15:0]  done_q[$];

    dma_read_block #(
        .CMD_FIFO_DEPTH(32),
        .MAX_BURST(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_master_addr_o(rd_master_addr_o),
        .rd_master_read_o(rd_master_read_o),
        .rd_master_bcount_o(rd_master_bcount_o),
        .rd_master_wait_req_i(rd_master_wait_req_i),
        .rd_master_data_i(rd_master_data_i),
        .rd_master_data_valid_i(rd_master_data_valid_i),
        .dma_rd_fifo_command_req_i(dma_rd_fifo_command_req_i),
        .dma_rd_bytes_to_transfer_i(dma_rd_bytes_to_transfer_i),
        .dma_rd_addr_i(dma_rd_addr_i),
        .dma_rd_fifo_full_o(dma_rd_fifo_full_o),
        .dma_data_fifo_wr_req_o(dma_data_fifo_wr_req_o),
        .dma_data_o(dma_data_o),
        .dma_data_fifo_almost_full_i(dma_data_fifo_almost_full_i),
`ifdef DMA_RD_STALL_CNT_EN
        .rd_stall_count_o(rd_stall_count_o),
`endif
        .dma_rd_done_o(dma_rd_done_o),
        .dma_rd_bytes_done_o(dma_rd_bytes_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{a}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the push for exactly one clock.
    task automatic applyStimulus(input logic [15:0] bytes, input logic [31:0] addr);
        dma_rd_fifo_command_req_i  = 1'b1;
        dma_rd_bytes_to_transfer_i = bytes;
        dma_rd_addr_i              = addr;
        @(negedge clk);
        dma_rd_fifo_command_req_i  = 1'b0;
    endtask

    task automatic waitDone(input int n, input int budget);
        int t;
        t = 0;
        while (done_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_count", 256'(done_q.size()), 256'(n));
        repeat (5) @(negedge clk);
    endtask

    task automatic waitWrites(input int n, input int budget);
        int t;
        t = 0;
        while (got_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (got_data.size() < n) begin
            checkOutput("write_timeout", 256'(got_data.size()), 256'(n));
        end
    endtask

    task automatic clearLogs();
        burst_addr_q.delete();
        burst_cnt_q.delete();
        got_data.delete();
        valid_cyc_q.delete();
        wr_cyc_q.delete();
        done_q.delete();
        stall_seen = 0;
    endtask

    // Avalon read slave: optional waitrequest stall, then consecutive beats of {8{beat address}}.
    initial begin : slave
        logic [31:0] a0;
        logic [10:0] b0;
        int          nbeats;
        rd_master_wait_req_i   = 1'b0;
        rd_master_data_valid_i = 1'b0;
        rd_master_data_i       = '0;
        forever begin
            @(negedge clk);
            if (rd_master_read_o && !reset) begin
                a0 = rd_master_addr_o;
                b0 = rd_master_bcount_o;
                if (stall_cfg > 0) begin
                    rd_master_wait_req_i = 1'b1;
                    for (int i = 0; i < stall_cfg; i++) begin
                        @(negedge clk);
                        checkOutput("stall_hold",
                                    256'(rd_master_read_o && rd_master_addr_o == a0 && rd_master_bcount_o == b0),
                                    256'd1);
                    end
                    rd_master_wait_req_i = 1'b0;
                end
                burst_addr_q.push_back(a0);
                burst_cnt_q.push_back(b0);
                @(negedge clk);
                slave_busy = 1'b1;
                nbeats = (int'(b0) < beat_limit) ? int'(b0) : beat_limit;
                for (int j = 0; j < nbeats; j++) begin
                    rd_master_data_valid_i = 1'b1;
                    rd_master_data_i       = pat(a0 + 32'(j) * 32);
                    valid_cyc_q.push_back(cyc);
                    @(negedge clk);
                end
                rd_master_data_valid_i = 1'b0;
                slave_busy             = 1'b0;
            end else if (stray_req > 0) begin
                rd_master_data_valid_i = 1'b1;
                rd_master_data_i       = {8{32'hDEAD_BEEF}};
                stray_req--;
                @(negedge clk);
                rd_master_data_valid_i = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (dma_data_fifo_wr_req_o) begin
                got_data.push_back(dma_data_o);
                wr_cyc_q.push_back(cyc);
            end
            if (dma_rd_done_o) done_q.push_back(dma_rd_bytes_done_o);
            if (rd_master_read_o) read_hi++;
            if (rd_master_read_o && rd_master_wait_req_i) stall_seen++;
            if (rd_master_read_o && slave_busy) overlap++;
        end
    end

    initial begin
        int r0, w0, d0;
        reset                       = 1'b1;
        dma_rd_fifo_command_req_i   = 1'b0;
        dma_rd_bytes_to_transfer_i  = '0;
        dma_rd_addr_i               = '0;
        dma_data_fifo_almost_full_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_read",   256'(rd_master_read_o), 256'd0);
        checkOutput("rst_addr",   256'(rd_master_addr_o), 256'd0);
        checkOutput("rst_bcount", 256'(rd_master_bcount_o), 256'd0);
        checkOutput("rst_full",   256'(dma_rd_fifo_full_o), 256'd0);
        checkOutput("rst_wr",     256'(dma_data_fifo_wr_req_o), 256'd0);
        checkOutput("rst_done",   256'(dma_rd_done_o), 256'd0);
        checkOutput("rst_bytes",  256'(dma_rd_bytes_done_o), 256'd0);

        // 64 bytes at 0x1000: one 2-beat burst
        clearLogs();
        applyStimulus(16'd64, 32'h0000_1000);
        waitDone(1, 200);
        checkOutput("t1_bursts", 256'(burst_addr_q.size()), 256'd1);
        checkOutput("t1_addr",   256'(burst_addr_q[0]), 256'h1000);
        checkOutput("t1_bcount", 256'(burst_cnt_q[0]), 256'd2);
        checkOutput("t1_writes", 256'(got_data.size()), 256'd2);
        checkOutput("t1_data0",  got_data[0], pat(32'h0000_1000));
        checkOutput("t1_data1",  got_data[1], pat(32'h0000_1020));
        checkOutput("t1_lat0",   256'(wr_cyc_q[0] - valid_cyc_q[0]), 256'd1);
        checkOutput("t1_lat1",   256'(wr_cyc_q[1] - valid_cyc_q[1]), 256'd1);
        checkOutput("t1_bytes",  256'(done_q[0]), 256'd64);

        // 1000 bytes = 32 beats, split in two bursts, address wraps past 2^32
        clearLogs();
        applyStimulus(16'd1000, 32'hFFFF_FE00);
        waitDone(1, 400);
        repeat (10) @(negedge clk);
        checkOutput("t2_bursts",  256'(burst_addr_q.size()), 256'd2);
        checkOutput("t2_addr0",   256'(burst_addr_q[0]), 256'hFFFF_FE00);
        checkOutput("t2_bcount0", 256'(burst_cnt_q[0]), 256'd16);
        checkOutput("t2_addr1",   256'(burst_addr_q[1]), 256'h0);
        checkOutput("t2_bcount1", 256'(burst_cnt_q[1]), 256'd16);
        checkOutput("t2_writes",  256'(got_data.size()), 256'd32);
        checkOutput("t2_first",   got_data[0], pat(32'hFFFF_FE00));
        checkOutput("t2_last",    got_data[31], pat(32'h0000_01E0));
        checkOutput("t2_ndone",   256'(done_q.size()), 256'd1);
        checkOutput("t2_bytes",   256'(done_q[0]), 256'd1000);

        // waitrequest held for 5 cycles
        clearLogs();
        stall_cfg = 5;
        applyStimulus(16'd64, 32'h0000_2000);
        waitDone(1, 200);
        stall_cfg = 0;
        checkOutput("t3_stall_cycles", 256'(stall_seen), 256'd5);
        checkOutput("t3_addr",  256'(burst_addr_q[0]), 256'h2000);
        checkOutput("t3_bytes", 256'(done_q[0]), 256'd64);
`ifdef DMA_RD_STALL_CNT_EN
        checkOutput("t3_stall_count", 256'(rd_stall_count_o), 256'd5);
`endif

        // almost_full between bursts plus a stray valid while in CHECK
        clearLogs();
        applyStimulus(16'd1024, 32'h0000_3000);
        waitWrites(1, 100);
        dma_data_fifo_almost_full_i = 1'b1;
        waitWrites(16, 100);
        repeat (2) @(negedge clk);
        r0 = read_hi;
        w0 = got_data.size();
        stray_req = 1;
        repeat (10) @(negedge clk);
        checkOutput("t4_no_read", 256'(read_hi), 256'(r0));
        checkOutput("t4_stray",   256'(got_data.size()), 256'(w0));
        dma_data_fifo_almost_full_i = 1'b0;
        waitDone(1, 300);
        checkOutput("t4_bursts", 256'(burst_addr_q.size()), 256'd2);
        checkOutput("t4_addr1",  256'(burst_addr_q[1]), 256'h3200);
        checkOutput("t4_writes", 256'(got_data.size()), 256'd32);
        checkOutput("t4_bytes",  256'(done_q[0]), 256'd1024);

        // zero-byte command followed by a 33-byte command
        clearLogs();
        applyStimulus(16'd0, 32'h0000_4000);
        applyStimulus(16'd33, 32'h0000_5000);
        waitDone(2, 300);
        checkOutput("t5_bytes0",  256'(done_q[0]), 256'd0);
        checkOutput("t5_bytes1",  256'(done_q[1]), 256'd33);
        checkOutput("t5_bursts",  256'(burst_addr_q.size()), 256'd1);
        checkOutput("t5_addr",    256'(burst_addr_q[0]), 256'h5000);
        checkOutput("t5_bcount",  256'(burst_cnt_q[0]), 256'd2);
        checkOutput("t5_writes",  256'(got_data.size()), 256'd2);

        // engine parked in CHECK, then 33 pushes into the 32-entry command FIFO
        clearLogs();
        dma_data_fifo_almost_full_i = 1'b1;
        applyStimulus(16'd64, 32'h0000_6000);
        repeat (6) @(negedge clk);
        for (int i = 1; i <= 33; i++) begin
            if (i == 32) checkOutput("t6_full_31", 256'(dma_rd_fifo_full_o), 256'd0);
            applyStimulus(16'(i), 32'h0000_6000 + 32'(i) * 32'h100);
            if (i == 32) checkOutput("t6_full_32", 256'(dma_rd_fifo_full_o), 256'd1);
        end
        checkOutput("t6_full_33", 256'(dma_rd_fifo_full_o), 256'd1);
        dma_data_fifo_almost_full_i = 1'b0;
        waitDone(33, 3000);
        repeat (30) @(negedge clk);
        checkOutput("t6_ndone",  256'(done_q.size()), 256'd33);
        checkOutput("t6_first",  256'(done_q[0]), 256'd64);
        checkOutput("t6_last",   256'(done_q[32]), 256'd32);
        checkOutput("t6_empty",  256'(dma_rd_fifo_full_o), 256'd0);

        // reset while WAIT_DATA with a second command still queued
        clearLogs();
        beat_limit = 1;
        applyStimulus(16'd64, 32'h0000_7000);
        applyStimulus(16'd64, 32'h0000_8000);
        waitWrites(1, 100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        beat_limit = 1000;
        checkOutput("t7_read",   256'(rd_master_read_o), 256'd0);
        checkOutput("t7_addr",   256'(rd_master_addr_o), 256'd0);
        checkOutput("t7_wr",     256'(dma_data_fifo_wr_req_o), 256'd0);
        checkOutput("t7_done",   256'(dma_rd_done_o), 256'd0);
        checkOutput("t7_bytes",  256'(dma_rd_bytes_done_o), 256'd0);
        checkOutput("t7_full",   256'(dma_rd_fifo_full_o), 256'd0);
`ifdef DMA_RD_STALL_CNT_EN
        checkOutput("t7_stall_count", 256'(rd_stall_count_o), 256'd0);
`endif
        r0 = read_hi;
        w0 = got_data.size();
        d0 = done_q.size();
        stray_req = 2;
        repeat (20) @(negedge clk);
        checkOutput("t7_no_read",   256'(read_hi), 256'(r0));
        checkOutput("t7_no_write",  256'(got_data.size()), 256'(w0));
        checkOutput("t7_no_done",   256'(done_q.size()), 256'(d0));

        checkOutput("one_burst_outstanding", 256'(overlap), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_read_block.md
Name: dma_read_block

Overview:
- Source-side engine of the scatter-gather DMA. Accepts read commands (byte count, source address) from the descriptor processor and issues Avalon-MM burst reads on a 256-bit master port.
- Returned beats are pushed into the shared DMA data FIFO, which the write block drains.
- Signals per-command completion back to the descriptor processor.

Parameters:
- CMD_FIFO_DEPTH, 32, command FIFO entries (power of 2); widthu = log2(CMD_FIFO_DEPTH).
- MAX_BURST, 16, maximum beats per Avalon burst (1..1024). The data FIFO almost_full threshold must leave at least MAX_BURST free entries.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_master_addr_o  out  32  burst byte address
- rd_master_read_o  out  1  read request
- rd_master_bcount_o  out  11  burst length in 32-byte beats
- rd_master_wait_req_i  in  1  Avalon waitrequest
- rd_master_data_i  in  256  read data
- rd_master_data_valid_i  in  1  readdatavalid
- dma_rd_fifo_command_req_i  in  1  push command
- dma_rd_bytes_to_transfer_i  in  16  command byte count
- dma_rd_addr_i  in  32  command source address
- dma_rd_fifo_full_o  out  1  command FIFO full
- dma_data_fifo_wr_req_o  out  1  data FIFO write
- dma_data_o  out  256  data FIFO write data
- dma_data_fifo_almost_full_i  in  1  data FIFO back-pressure
- dma_rd_done_o  out  1  one-cycle pulse, command complete
- dma_rd_bytes_done_o  out  16  byte count of last completed command

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Command FIFO cleared via sclr.
  - Beat and outstanding counters 0.
- Command FIFO:
  - scfifo, 48 bits {bytes[15:0], addr[31:0]}, show-ahead off, q valid one cycle after rdreq.
  - A push while full is dropped (overflow checking on); dma_rd_fifo_full_o is the FIFO full flag.
- Beat arithmetic:
  - total_beats = bytes[15:5] + |bytes[4:0], 11 bits.
  - Each burst length = min(remaining_beats, MAX_BURST).
  - Burst address = cmd_addr + beats_issued*32, computed modulo 2^32 (wraps, no error).
- State machine:
  - IDLE: go to RD_CMD_FIFO if the FIFO is not empty.
  - RD_CMD_FIFO: assert rdreq for one cycle; go to LD_CMD_REG.
  - LD_CMD_REG: latch q, load remaining_beats = total_beats, beats_issued = 0.
    - Go to DONE if total_beats == 0. A zero-byte command issues no read.
    - Otherwise go to CHECK.
  - CHECK: wait until ~dma_data_fifo_almost_full_i.
    - Then register addr and bcount, set rd_master_read_o, go to ISSUE.
  - ISSUE: hold read, addr and bcount stable while wait_req is high.
    - On the cycle read & ~wait_req: deassert read next cycle, outstanding = bcount, remaining_beats -= bcount, beats_issued += bcount, go to WAIT_DATA.
  - WAIT_DATA: each data_valid decrements outstanding.
    - When the last beat arrives (outstanding == 1 & data_valid): go to DONE if remaining_beats == 0, else go to CHECK.
  - DONE: dma_rd_done_o = 1 for exactly one cycle; dma_rd_bytes_done_o <= cmd bytes, held until the next DONE. Go to IDLE.
  - Default (any other encoding): go to IDLE.
- Data path:
  - dma_data_fifo_wr_req_o is data_valid registered; dma_data_o is data registered (1-cycle latency).
  - Forward data only while in WAIT_DATA. Any data_valid in other states is discarded and not counted.
- Burst ordering: only one burst is outstanding at any time. The next burst is never issued before all beats of the previous burst have returned.
- Reset mid-operation: read drops immediately, the state machine returns to IDLE, and in-flight beats returning after reset are discarded. The interconnect is reset together with this block.
- Simultaneous push and pop on the command FIFO are both honoured.

Optional Feature:
- Macro: DMA_RD_STALL_CNT_EN.
- Defined:
  - Adds output rd_stall_count_o [31:0], reset to 0.
  - Increments on every cycle with rd_master_read_o & rd_master_wait_req_i.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single command, bytes=64, addr=0x1000, no waitrequest, valids on consecutive cycles -> one burst, addr 0x1000, bcount 2. Two data FIFO writes carrying identical data one cycle after each valid. Done pulse with bytes_done=64.
- bytes=1000 (32 beats, 1000/32 rounded up), MAX_BURST=16, addr=0xFFFF_FE00 -> bursts at 0xFFFF_FE00 with bcount 16, then 0x0000_0000 (wrap) with bcount 16. 32 FIFO writes, one done pulse with bytes_done=1000.
- waitrequest held high for 5 cycles in ISSUE -> read, addr and bcount stable for all 5 cycles; burst accepted on cycle 6. With DMA_RD_STALL_CNT_EN, rd_stall_count_o=5.
- data_fifo_almost_full high for 10 cycles between bursts -> no read asserted until it drops. A stray data_valid outside WAIT_DATA produces no FIFO write.
- bytes=0 command, then bytes=33 command queued -> first: done pulse with bytes_done=0 and no read. Second: bcount 2, done with bytes_done=33.
- 33 back-to-back pushes with the engine stalled -> full_o asserts after 32 pushes and the 33rd push is dropped. Reset asserted during WAIT_DATA -> outputs 0, FIFO empty, later valids ignored.
